nios2_onchip_mem_streamer: RTL and testbench
============================================

NIOS2_ONCHIP_MEM_STREAMER -- requirements
Module: nios2_onchip_mem_streamer

Interface
REQ-001 SHALL provide parameter ADDR_W, default 11, word-address width of the on-chip memory.
REQ-002 SHALL provide parameter DATA_W, default 32, memory and stream data width.
REQ-003 SHALL provide parameter CNT_W, default 12, transfer length width (max 2048 words).
REQ-004 SHALL use one clock; reset is synchronous and active-high; ports: clk  input  1  clock; reset  input  1  sync active-high reset.
REQ-005 start  input  1  one-cycle command strobe; sampled only in IDLE.
REQ-006 base_addr  input  ADDR_W  first word address; sampled with start.
REQ-007 word_count  input  CNT_W  number of words; sampled with start.
REQ-008 busy  output  1  high from accepted start until done.
REQ-009 done  output  1  one-cycle pulse at end of transfer.
REQ-010 checksum  output  DATA_W  mod-2^DATA_W sum of delivered words; valid while done=1, held until next start.
REQ-011 mem_address  output  ADDR_W  memory word address.
REQ-012 mem_chipselect  output  1  read issue strobe.
REQ-013 mem_write  output  1  constant 0.
REQ-014 mem_byteenable  output  4  constant 4'hF.
REQ-015 mem_writedata  output  DATA_W  constant 0.
REQ-016 mem_clken  output  1  constant 1.
REQ-017 mem_readdata  input  DATA_W  memory read data, valid exactly 1 cycle after the issuing chipselect cycle.
REQ-018 out_data  output  DATA_W  stream data.
REQ-019 out_valid  output  1  stream valid.
REQ-020 out_ready  input  1  stream ready from consumer.
REQ-021 out_last  output  1  high with the final word of a transfer.

Function
REQ-022 SHALL implement FSM IDLE -> READ -> DRAIN -> IDLE.
REQ-023 IDLE: start=1 with word_count in 1..2048 SHALL latch base_addr and count, set busy, go to READ next cycle.
REQ-024 word_count=0 with start SHALL produce done=1 the next cycle with checksum=0, no memory access, stay IDLE.
REQ-025 word_count>2048 SHALL be saturated to 2048.
REQ-026 start while busy SHALL be ignored.
REQ-027 READ: SHALL assert mem_chipselect for one read only when (buffer occupancy + reads in flight) < 2; each issue increments mem_address.
REQ-028 mem_address SHALL wrap modulo 2^ADDR_W (2047 -> 0).
REQ-029 When all reads are issued, SHALL go to DRAIN; DRAIN -> IDLE on acceptance (out_valid & out_ready) of the out_last word.
REQ-030 mem_readdata SHALL be captured one cycle after each issue into a 2-entry FIFO; no word lost or duplicated under any out_ready pattern.
REQ-031 out_valid SHALL stay high and out_data/out_last stable until accepted.
REQ-032 With out_ready held high, SHALL sustain one word per cycle after a 2-cycle start-to-first-valid latency (start cycle + issue cycle).
REQ-033 checksum SHALL accumulate each accepted word; done SHALL pulse in the cycle after the last acceptance, busy dropping in the same cycle.
REQ-034 mem_chipselect SHALL be 0 outside READ.

Reset
REQ-035 On reset: state IDLE, busy=0, done=0, checksum=0, out_valid=0, out_last=0, out_data=0, mem_chipselect=0, mem_address=0, FIFO emptied.
REQ-036 Reset mid-transfer SHALL abort; a read in flight SHALL be discarded, not delivered.

Structure
REQ-037 FSM state encoding, ADDR_W/DATA_W/CNT_W defaults and max-length constant (2048) SHALL live in shared package nios2_mem_pkg.
REQ-038 The 2-entry FIFO SHALL be sub-module nios2_skid_fifo2 (DATA_W+1 wide: data plus last flag).

Verification
REQ-039 Memory model preloaded mem[k]=k+1; start base=0,count=4, out_ready=1 -> words 1,2,3,4 on consecutive cycles, last on 4, done with checksum=10.
REQ-040 base=2046,count=4 -> addresses 2046,2047,0,1 issued; data 2047,2048,1,2; checksum=4098.
REQ-041 count=16, out_ready random 50% -> exactly 16 words in order 1..16, never >2 reads outstanding, checksum=136.
REQ-042 count=0 -> done next cycle, checksum=0, mem_chipselect never asserted; count=3000 -> 2048 words delivered.
REQ-043 start during busy -> ignored, original transfer completes unchanged.
REQ-044 reset asserted 3 cycles into count=8 transfer -> all outputs at reset values next cycle; new start base=0,count=2 delivers 1,2 only.

Source files
------------

// File: rtl/nios2_mem_pkg.sv
// Shared types and constants for the on-chip memory streamer.
// Latency: n/a (declarations only).
// Backpressure: n/a.
package nios2_mem_pkg;

  localparam int ADDR_W_DEF = 11;
  localparam int DATA_W_DEF = 32;
  localparam int CNT_W_DEF  = 12;

  // Longest transfer a single start may request; larger counts saturate.
  localparam int unsigned MAX_WORDS = 2048;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_READ  = 2'd1,
    ST_DRAIN = 2'd2
  } state_t;

  function automatic int unsigned clamp_len(input int unsigned n);
    return (n > MAX_WORDS) ? MAX_WORDS : n;
  endfunction

endpackage

// File: rtl/nios2_onchip_mem_streamer_if.sv
// Memory read port plus outbound word stream of the streamer.
// Latency: n/a (wires only).
// Backpressure: out_ready from the consumer; memory side has none.
// master: streamer side (drives mem_* controls, out_data/out_valid/out_last).
// slave:  memory + consumer side (drives mem_readdata, out_ready).
interface nios2_onchip_mem_streamer_if
  import nios2_mem_pkg::*;
#(
  parameter int ADDR_W = ADDR_W_DEF,
  parameter int DATA_W = DATA_W_DEF
);
  logic [ADDR_W-1:0] mem_address;
  logic              mem_chipselect;
  logic              mem_write;
  logic [3:0]        mem_byteenable;
  logic [DATA_W-1:0] mem_writedata;
  logic              mem_clken;
  logic [DATA_W-1:0] mem_readdata;
  logic [DATA_W-1:0] out_data;
  logic              out_valid;
  logic              out_ready;
  logic              out_last;

  modport master (
    output mem_address, mem_chipselect, mem_write, mem_byteenable,
    output mem_writedata, mem_clken,
    input  mem_readdata,
    output out_data, out_valid, out_last,
    input  out_ready
  );

  modport slave (
    input  mem_address, mem_chipselect, mem_write, mem_byteenable,
    input  mem_writedata, mem_clken,
    output mem_readdata,
    input  out_data, out_valid, out_last,
    output out_ready
  );
endinterface

// File: rtl/nios2_skid_fifo2.sv
// Two-entry FIFO with bypass: an incoming word is presented in the cycle it arrives.
// Latency: 0 cycles when empty (combinational bypass), otherwise head-of-queue order.
// Backpressure: no in_rdy; the writer must keep occupancy + pending writes <= 2 using cnt.
// Ports: clk/reset, in_vld/in_dat (write), out_vld/out_rdy/out_dat (read), cnt (stored entries).
module nios2_skid_fifo2 #(
  parameter int W = 33
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         in_vld,
  input  logic [W-1:0] in_dat,
  output logic         out_vld,
  input  logic         out_rdy,
  output logic [W-1:0] out_dat,
  output logic [1:0]   cnt
);
  logic [W-1:0] mem_q [2];
  logic         rd_ptr_q;
  logic         wr_ptr_q;
  logic [1:0]   cnt_q;
  logic         empty;
  logic         bypass;
  logic         push;
  logic         pop;

  assign empty  = (cnt_q == 2'd0);
  // A word that is consumed the same cycle it arrives never touches storage.
  assign bypass = empty && in_vld && out_rdy;
  assign push   = in_vld && !bypass;
  assign pop    = !empty && out_rdy;

  assign out_vld = !empty || in_vld;
  assign out_dat = !empty ? mem_q[rd_ptr_q] : (in_vld ? in_dat : '0);
  assign cnt     = cnt_q;

  always_ff @(posedge clk) begin
    if (push) mem_q[wr_ptr_q] <= in_dat;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      rd_ptr_q <= 1'b0;
      wr_ptr_q <= 1'b0;
      cnt_q    <= 2'd0;
    end else begin
      if (push) wr_ptr_q <= !wr_ptr_q;
      if (pop)  rd_ptr_q <= !rd_ptr_q;
      cnt_q <= cnt_q + {1'b0, push} - {1'b0, pop};
    end
  end
endmodule

// File: rtl/nios2_onchip_mem_streamer.sv
// Streams word_count words from on-chip memory starting at base_addr, summing them.
// Latency: first word valid 2 cycles after the start cycle; 1 word/cycle with out_ready high.
// Backpressure: out_ready low stalls; reads are only issued while buffer + in-flight < 2.
// Ports: clk/reset; start/base_addr/word_count command; busy/done/checksum status;
//        bus (master): mem_* read port and out_data/out_valid/out_ready/out_last stream.
module nios2_onchip_mem_streamer
  import nios2_mem_pkg::*;
#(
  parameter int ADDR_W = ADDR_W_DEF,
  parameter int DATA_W = DATA_W_DEF,
  parameter int CNT_W  = CNT_W_DEF
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              start,
  input  logic [ADDR_W-1:0] base_addr,
  input  logic [CNT_W-1:0]  word_count,
  output logic              busy,
  output logic              done,
  output logic [DATA_W-1:0] checksum,
  nios2_onchip_mem_streamer_if.master bus
);
  state_t            state_q, state_d;
  logic [ADDR_W-1:0] addr_q;
  logic [CNT_W-1:0]  left_q;
  logic              inflight_q;
  logic              inflight_last_q;
  logic [DATA_W-1:0] checksum_q;
  logic              done_q;

  logic [CNT_W-1:0]  len_sat;
  logic [1:0]        fifo_cnt;
  logic              room;
  logic              issue;
  logic              accept;
  logic              fifo_vld;
  logic [DATA_W:0]   fifo_dat;

  assign len_sat = CNT_W'(clamp_len(32'(word_count)));

  // Credit check: stored words plus the word arriving this cycle must leave a slot.
  assign room   = ({1'b0, fifo_cnt} + {2'b00, inflight_q}) < 3'd2;
  assign accept = fifo_vld && bus.out_ready;

  always_comb begin
    state_d = state_q;
    issue   = 1'b0;
    case (state_q)
      ST_IDLE:  if (start && (word_count != '0)) state_d = ST_READ;
      ST_READ: begin
        issue = room;
        if (room && (left_q == CNT_W'(1))) state_d = ST_DRAIN;
      end
      ST_DRAIN: if (accept && fifo_dat[DATA_W]) state_d = ST_IDLE;
      default:  state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q         <= ST_IDLE;
      addr_q          <= '0;
      left_q          <= '0;
      inflight_q      <= 1'b0;
      inflight_last_q <= 1'b0;
      checksum_q      <= '0;
      done_q          <= 1'b0;
    end else begin
      state_q         <= state_d;
      done_q          <= 1'b0;
      inflight_q      <= issue;
      inflight_last_q <= issue && (left_q == CNT_W'(1));
      if ((state_q == ST_IDLE) && start) begin
        checksum_q <= '0;
        if (word_count == '0) begin
          done_q <= 1'b1;
        end else begin
          addr_q <= base_addr;
          left_q <= len_sat;
        end
      end
      if (issue) begin
        addr_q <= addr_q + ADDR_W'(1);
        left_q <= left_q - CNT_W'(1);
      end
      if (accept) checksum_q <= checksum_q + fifo_dat[DATA_W-1:0];
      if ((state_q == ST_DRAIN) && accept && fifo_dat[DATA_W]) done_q <= 1'b1;
    end
  end

  // Read data is tagged with its last flag so the flag travels with the word.
  nios2_skid_fifo2 #(.W(DATA_W + 1)) u_fifo (
    .clk     (clk),
    .reset   (reset),
    .in_vld  (inflight_q),
    .in_dat  ({inflight_last_q, bus.mem_readdata}),
    .out_vld (fifo_vld),
    .out_rdy (bus.out_ready),
    .out_dat (fifo_dat),
    .cnt     (fifo_cnt)
  );

  assign busy     = (state_q != ST_IDLE);
  assign done     = done_q;
  assign checksum = checksum_q;

  assign bus.mem_address    = addr_q;
  assign bus.mem_chipselect = issue;
  assign bus.mem_write      = 1'b0;
  assign bus.mem_byteenable = 4'hF;
  assign bus.mem_writedata  = '0;
  assign bus.mem_clken      = 1'b1;
  assign bus.out_data       = fifo_dat[DATA_W-1:0];
  assign bus.out_valid      = fifo_vld;
  assign bus.out_last       = fifo_vld && fifo_dat[DATA_W];
endmodule

// File: tb/tb_nios2_onchip_mem_streamer.sv
// Directed bench for the memory streamer with a registered memory model (mem[k] = k+1).
// Latency: n/a.
// Backpressure: out_ready driven either level or random per test.
module tb_nios2_onchip_mem_streamer;
  logic        clk = 1'b0;
  logic        reset;
  logic        start;
  logic [10:0] base_addr;
  logic [11:0] word_count;
  logic        busy;
  logic        done;
  logic [31:0] checksum;

  nios2_onchip_mem_streamer_if #(.ADDR_W(11), .DATA_W(32)) bus ();

  nios2_onchip_mem_streamer #(.ADDR_W(11), .DATA_W(32), .CNT_W(12)) dut (
    .clk        (clk),
    .reset      (reset),
    .start      (start),
    .base_addr  (base_addr),
    .word_count (word_count),
    .busy       (busy),
    .done       (done),
    .checksum   (checksum),
    .bus        (bus.master)
  );

  always #5 clk = !clk;

  logic [31:0] mem [0:2047];
  always @(posedge clk) begin
    if (bus.mem_chipselect) bus.mem_readdata <= mem[bus.mem_address];
  end

  bit ready_rand  = 1'b0;
  bit ready_level = 1'b1;
  always @(posedge clk) begin
    #1;
    bus.out_ready = ready_rand ? 1'($urandom_range(0, 1)) : ready_level;
  end

  int cycle_cnt = 0;
  always @(posedge clk) cycle_cnt++;

  // Observation log, written only by the monitor below.
  int          word_q[$];
  int          acc_cyc_q[$];
  bit          last_q[$];
  int          addr_q[$];
  int          cs_cnt = 0;
  int          done_hits = 0;
  int          out_cnt = 0;
  int          max_out = 0;
  int          hold_err = 0;
  bit          prev_stall = 1'b0;
  logic [31:0] prev_dat;
  bit          prev_last;

  always @(negedge clk) begin
    if (reset) begin
      out_cnt    = 0;
      prev_stall = 1'b0;
    end else begin
      if (prev_stall && (!bus.out_valid || bus.out_data != prev_dat || bus.out_last != prev_last))
        hold_err++;
      if (bus.mem_chipselect) begin
        cs_cnt++;
        addr_q.push_back(int'(bus.mem_address));
        out_cnt++;
      end
      if (out_cnt > max_out) max_out = out_cnt;
      if (bus.out_valid && bus.out_ready) begin
        word_q.push_back(int'(bus.out_data));
        acc_cyc_q.push_back(cycle_cnt);
        last_q.push_back(bus.out_last);
        out_cnt--;
      end
      if (done) done_hits++;
      prev_stall = bus.out_valid && !bus.out_ready;
      prev_dat   = bus.out_data;
      prev_last  = bus.out_last;
    end
  end

  function automatic int wget(input int i);
    return (i < word_q.size()) ? word_q[i] : -1;
  endfunction
  function automatic int cget(input int i);
    return (i < acc_cyc_q.size()) ? acc_cyc_q[i] : -1;
  endfunction
  function automatic bit lget(input int i);
    return (i < last_q.size()) ? last_q[i] : 1'b0;
  endfunction
  function automatic int aget(input int i);
    return (i < addr_q.size()) ? addr_q[i] : -1;
  endfunction

  int total = 0;
  int bad   = 0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%0d expected=%0d", tag, got, exp);
    end
  endtask

  int          start_cyc;
  bit          d_seen;
  logic [31:0] d_ck;
  bit          d_busy;
  int          d_cyc;

  task automatic do_start(input int b, input int n);
    @(posedge clk);
    #1;
    start      = 1'b1;
    base_addr  = 11'(b);
    word_count = 12'(n);
    start_cyc  = cycle_cnt;
    @(posedge clk);
    #1;
    start = 1'b0;
  endtask

  task automatic wait_done(input int budget);
    d_seen = 1'b0;
    for (int i = 0; i < budget; i++) begin
      @(negedge clk);
      if (done) begin
        d_seen = 1'b1;
        d_ck   = checksum;
        d_busy = busy;
        d_cyc  = cycle_cnt;
        break;
      end
    end
  endtask

  task automatic idle(input int n);
    repeat (n) @(posedge clk);
  endtask

  int mw, ma, mc, md, err;

  initial begin
    for (int k = 0; k < 2048; k++) mem[k] = 32'(k + 1);
    reset = 1'b1; start = 1'b0; base_addr = '0; word_count = '0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("rst_busy", busy, 0);
    chk("rst_done", done, 0);
    chk("rst_checksum", checksum, 0);
    chk("rst_out_valid", bus.out_valid, 0);
    chk("rst_out_last", bus.out_last, 0);
    chk("rst_out_data", bus.out_data, 0);
    chk("rst_chipselect", bus.mem_chipselect, 0);
    chk("rst_address", bus.mem_address, 0);
    chk("const_write", bus.mem_write, 0);
    chk("const_byteenable", bus.mem_byteenable, 4'hF);
    chk("const_writedata", bus.mem_writedata, 0);
    chk("const_clken", bus.mem_clken, 1);
    reset = 1'b0;

    // Basic 4-word transfer, full throughput.
    mw = word_q.size(); md = done_hits;
    do_start(0, 4);
    @(negedge clk);
    chk("t1_busy", busy, 1);
    wait_done(50);
    chk("t1_done_seen", d_seen, 1);
    chk("t1_checksum", d_ck, 10);
    chk("t1_busy_at_done", d_busy, 0);
    idle(3);
    chk("t1_nwords", word_q.size() - mw, 4);
    for (int i = 0; i < 4; i++) begin
      chk($sformatf("t1_word%0d", i), wget(mw + i), i + 1);
      chk($sformatf("t1_last%0d", i), lget(mw + i), (i == 3) ? 1 : 0);
    end
    chk("t1_latency", cget(mw) - start_cyc, 2);
    chk("t1_back_to_back", cget(mw + 3) - cget(mw), 3);
    chk("t1_done_cycle", d_cyc - cget(mw + 3), 1);
    chk("t1_done_pulses", done_hits - md, 1);

    // Address wrap at the top of memory.
    mw = word_q.size(); ma = addr_q.size();
    do_start(2046, 4);
    wait_done(50);
    chk("t2_done_seen", d_seen, 1);
    chk("t2_checksum", d_ck, 4098);
    idle(3);
    chk("t2_naddr", addr_q.size() - ma, 4);
    chk("t2_addr0", aget(ma + 0), 2046);
    chk("t2_addr1", aget(ma + 1), 2047);
    chk("t2_addr2", aget(ma + 2), 0);
    chk("t2_addr3", aget(ma + 3), 1);
    chk("t2_word0", wget(mw + 0), 2047);
    chk("t2_word1", wget(mw + 1), 2048);
    chk("t2_word2", wget(mw + 2), 1);
    chk("t2_word3", wget(mw + 3), 2);

    // Random backpressure.
    mw = word_q.size();
    ready_rand = 1'b1;
    do_start(0, 16);
    wait_done(400);
    ready_rand = 1'b0;
    chk("t3_done_seen", d_seen, 1);
    chk("t3_checksum", d_ck, 136);
    idle(3);
    chk("t3_nwords", word_q.size() - mw, 16);
    err = 0;
    for (int i = 0; i < 16; i++) if (wget(mw + i) != i + 1) err++;
    chk("t3_order_errors", err, 0);
    chk("t3_last_flag", lget(mw + 15), 1);
    chk("t3_max_outstanding_le2", (max_out <= 2) ? 1 : 0, 1);
    chk("t3_hold_errors", hold_err, 0);

    // Zero-length request.
    mw = word_q.size(); mc = cs_cnt;
    do_start(5, 0);
    wait_done(5);
    chk("t4_done_seen", d_seen, 1);
    chk("t4_done_cycle", d_cyc - start_cyc, 1);
    chk("t4_checksum", d_ck, 0);
    chk("t4_busy", d_busy, 0);
    idle(3);
    chk("t4_chipselects", cs_cnt - mc, 0);
    chk("t4_nwords", word_q.size() - mw, 0);

    // Oversized request saturates to 2048 words.
    mw = word_q.size();
    do_start(0, 3000);
    wait_done(2300);
    chk("t5_done_seen", d_seen, 1);
    chk("t5_checksum", d_ck, 2098176);
    idle(3);
    chk("t5_nwords", word_q.size() - mw, 2048);
    err = 0;
    for (int i = 0; i < 2048; i++) if (wget(mw + i) != i + 1) err++;
    chk("t5_order_errors", err, 0);
    chk("t5_last_flag", lget(mw + 2047), 1);

    // Start while busy is ignored.
    mw = word_q.size(); md = done_hits;
    do_start(0, 4);
    #1;
    @(posedge clk);
    #1;
    start = 1'b1; base_addr = 11'd100; word_count = 12'd2;
    @(posedge clk);
    #1;
    start = 1'b0;
    wait_done(50);
    chk("t6_done_seen", d_seen, 1);
    chk("t6_checksum", d_ck, 10);
    idle(3);
    chk("t6_nwords", word_q.size() - mw, 4);
    chk("t6_word0", wget(mw), 1);
    chk("t6_word3", wget(mw + 3), 4);
    chk("t6_done_pulses", done_hits - md, 1);

    // Reset three cycles into an 8-word transfer.
    do_start(0, 8);
    @(posedge clk);
    @(posedge clk);
    #1;
    reset = 1'b1;
    @(posedge clk);
    @(negedge clk);
    chk("t7_busy", busy, 0);
    chk("t7_done", done, 0);
    chk("t7_checksum", checksum, 0);
    chk("t7_out_valid", bus.out_valid, 0);
    chk("t7_out_last", bus.out_last, 0);
    chk("t7_out_data", bus.out_data, 0);
    chk("t7_chipselect", bus.mem_chipselect, 0);
    chk("t7_address", bus.mem_address, 0);
    reset = 1'b0;
    @(negedge clk);
    chk("t7_no_stale_valid", bus.out_valid, 0);
    mw = word_q.size();
    do_start(0, 2);
    wait_done(50);
    chk("t7_done_seen", d_seen, 1);
    chk("t7_checksum_after", d_ck, 3);
    idle(3);
    chk("t7_nwords", word_q.size() - mw, 2);
    chk("t7_word0", wget(mw), 1);
    chk("t7_word1", wget(mw + 1), 2);

    chk("max_outstanding_le2", (max_out <= 2) ? 1 : 0, 1);
    chk("hold_errors", hold_err, 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
